dmem_port_arbiter: RTL and testbench



---
 rtl/dmem_port_arbiter.sv | 106 ++++++++++
 tb/tb_dmem_port_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_port_arbiter.sv
// Round-robin arbiter sharing one synchronous data-memory port between the
// CPU load/store path and the debug requester; one access per three cycles.
module dmem_port_arbiter #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic              cpu_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_ack,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t            state;
  state_t            next_state;
  logic              grant;
  logic              win_id;
  logic              sel_id;
  logic              last_id;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  // Requester id 0 is the CPU, 1 is debug; on a tie the one not granted last wins.
  always_comb begin
    next_state = state;
    grant      = 1'b0;
    win_id     = 1'b0;
    mem_we     = 1'b0;
    cpu_ack    = 1'b0;
    dbg_ack    = 1'b0;
    unique case (state)
      IDLE: begin
        if (cpu_req || dbg_req) begin
          grant      = 1'b1;
          win_id     = (cpu_req && dbg_req) ? ~last_id : dbg_req;
          next_state = ACCESS;
        end
      end
      ACCESS: begin
        mem_we     = we_q;
        next_state = RESP;
      end
      RESP: begin
        cpu_ack    = ~sel_id;
        dbg_ack    = sel_id;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign cpu_stall = cpu_req & ~cpu_ack;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Synchronous RAM data is valid during RESP, so it is captured on that cycle's edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sel_id    <= 1'b0;
      last_id   <= 1'b1;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      cpu_rdata <= '0;
      dbg_rdata <= '0;
    end else begin
      if (grant) begin
        sel_id  <= win_id;
        last_id <= win_id;
        we_q    <= win_id ? dbg_we    : cpu_we;
        addr_q  <= win_id ? dbg_addr  : cpu_addr;
        wdata_q <= win_id ? dbg_wdata : cpu_wdata;
      end
      if (state == RESP && !we_q) begin
        if (sel_id) dbg_rdata <= mem_rdata;
        else        cpu_rdata <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: directed scenarios followed by random traffic,
// all checked cycle by cycle against a transaction-slot reference model.
module tb_dmem_port_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_req, cpu_we, dbg_req, dbg_we;
  logic [13:0] cpu_addr, dbg_addr, mem_addr;
  logic [31:0] cpu_wdata, dbg_wdata, cpu_rdata, dbg_rdata, mem_wdata, mem_rdata;
  logic        cpu_ack, dbg_ack, cpu_stall, mem_we;

  int tests  = 0;
  int failed = 0;

  dmem_port_arbiter #(.ADDR_W(14), .DATA_W(32)) dut (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_stall(cpu_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_rdata(dbg_rdata), .dbg_ack(dbg_ack),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;

  // Synchronous RAM behind the port.
  logic [31:0] ram [0:255] = '{default: '0};
  always @(posedge clock) begin
    if (mem_we) ram[mem_addr[7:0]] <= mem_wdata;
    mem_rdata <= ram[mem_addr[7:0]];
  end

  // Reference model: each grant opens a three-cycle slot starting at g_cyc.
  int          cyc, g_cyc;
  bit          g_who, g_we, m_last;
  logic [13:0] m_addr;
  logic [31:0] m_wdata, m_cpu_rdata, m_dbg_rdata;
  logic [31:0] ref_mem [int];

  int   ack_log [$];
  int   stall_cnt, we_cnt, dbg_ack_cnt;
  bit   seen_cpu_ack, seen_dbg_ack;

  bit          cp, dp, cw, dw;
  logic [13:0] ca, da;
  logic [31:0] cd, dd;
  int          cwait, dwait;

  function automatic void resetModel();
    cyc         = 0;
    g_cyc       = -3;
    g_who       = 1'b0;
    g_we        = 1'b0;
    m_last      = 1'b1;
    m_addr      = '0;
    m_wdata     = '0;
    m_cpu_rdata = '0;
    m_dbg_rdata = '0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      failed++;
      $error("[TB] FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  task automatic checkOutput();
    bit acc, rsp;
    acc = (cyc == g_cyc + 1);
    rsp = (cyc == g_cyc + 2);
    check("mem_we",    mem_we,    acc && g_we);
    check("cpu_ack",   cpu_ack,   rsp && !g_who);
    check("dbg_ack",   dbg_ack,   rsp && g_who);
    check("cpu_stall", cpu_stall, cpu_req && !(rsp && !g_who));
    check("mem_addr",  mem_addr,  m_addr);
    check("mem_wdata", mem_wdata, m_wdata);
    check("cpu_rdata", cpu_rdata, m_cpu_rdata);
    check("dbg_rdata", dbg_rdata, m_dbg_rdata);
    seen_cpu_ack = cpu_ack;
    seen_dbg_ack = dbg_ack;
    if (cpu_ack) ack_log.push_back(cyc * 2);
    if (dbg_ack) ack_log.push_back(cyc * 2 + 1);
    if (cpu_stall === 1'b1) stall_cnt++;
    if (mem_we === 1'b1) we_cnt++;
    if (dbg_ack === 1'b1) dbg_ack_cnt++;
  endtask

  function automatic void modelEdge();
    logic [31:0] v;
    if (cyc == g_cyc + 1 && g_we) ref_mem[int'(m_addr)] = m_wdata;
    if (cyc == g_cyc + 2 && !g_we) begin
      v = ref_mem.exists(int'(m_addr)) ? ref_mem[int'(m_addr)] : 32'h0;
      if (g_who) m_dbg_rdata = v;
      else       m_cpu_rdata = v;
    end
    if (cyc >= g_cyc + 3 && (cpu_req || dbg_req)) begin
      g_who   = (cpu_req && dbg_req) ? !m_last : dbg_req;
      m_last  = g_who;
      g_cyc   = cyc;
      g_we    = g_who ? dbg_we    : cpu_we;
      m_addr  = g_who ? dbg_addr  : cpu_addr;
      m_wdata = g_who ? dbg_wdata : cpu_wdata;
    end
  endfunction

  task automatic applyStimulus(input bit c_req, input bit c_we, input logic [13:0] c_addr,
                               input logic [31:0] c_wdata, input bit d_req, input bit d_we,
                               input logic [13:0] d_addr, input logic [31:0] d_wdata);
    cpu_req = c_req; cpu_we = c_we; cpu_addr = c_addr; cpu_wdata = c_wdata;
    dbg_req = d_req; dbg_we = d_we; dbg_addr = d_addr; dbg_wdata = d_wdata;
    @(negedge clock);
    checkOutput();
    modelEdge();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  initial begin
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
    resetModel();
    #2 reset = 1'b0;
    @(posedge clock); #1;
    cpu_req = 1'b1;
    #1;
    check("rst_cpu_ack",   cpu_ack,   1'b0);
    check("rst_dbg_ack",   dbg_ack,   1'b0);
    check("rst_mem_we",    mem_we,    1'b0);
    check("rst_mem_addr",  mem_addr,  32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_cpu_rdata", cpu_rdata, 32'h0);
    check("rst_dbg_rdata", dbg_rdata, 32'h0);
    check("rst_cpu_stall", cpu_stall, 1'b1);
    cpu_req = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    resetModel();

    // Contention from reset: CPU, dbg, CPU, dbg at cycles 2, 5, 8, 11.
    for (int i = 0; i < 12; i++) applyStimulus(1, 0, 14'h20, 0, 1, 0, 14'h30, 0);
    check("contention_acks", ack_log.size(), 4);
    if (ack_log.size() == 4) begin
      check("contention_ack0", ack_log[0], 4);
      check("contention_ack1", ack_log[1], 11);
      check("contention_ack2", ack_log[2], 16);
      check("contention_ack3", ack_log[3], 23);
    end

    // CPU write then read back.
    stall_cnt = 0; we_cnt = 0;
    for (int i = 0; i < 3; i++) applyStimulus(1, 1, 14'h10, 32'hDEADBEEF, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 14'h10, 0, 0, 0, 0, 0);
    check("wr_rd_rdata", cpu_rdata, 32'hDEADBEEF);
    check("wr_rd_stall_cycles", stall_cnt, 4);
    check("wr_rd_we_cycles", we_cnt, 1);

    // Single requester streaming reads.
    for (int i = 0; i < 3; i++) applyStimulus(1, 1, 14'h1, 32'h11111111, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(1, 1, 14'h2, 32'h22222222, 0, 0, 0, 0);
    dbg_ack_cnt = 0;
    for (int i = 0; i < 9; i++) applyStimulus(0, 0, 0, 0, 1, 0, 14'(i / 3), 0);
    check("stream_dbg_acks", dbg_ack_cnt, 3);
    check("stream_dbg_rdata", dbg_rdata, 32'h22222222);
    check("stream_cpu_rdata", cpu_rdata, 32'hDEADBEEF);

    // Request dropped right after the IDLE cycle still completes.
    applyStimulus(1, 1, 14'h5, 32'h5A, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 14'h5, 0, 0, 0, 0, 0);
    check("early_drop_rdata", cpu_rdata, 32'h5A);

    // A write must not disturb the requester's read data.
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 1, 1, 14'h40, 32'h1234);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 1, 0, 14'h40, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 1, 1, 14'h40, 32'hFFFF);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    check("wr_keeps_dbg_rdata", dbg_rdata, 32'h1234);

    // Reset during ACCESS of a CPU write loses the access; it is redone afterwards.
    applyStimulus(1, 1, 14'h50, 32'h77, 0, 0, 0, 0);
    check("mid_rst_we_before", mem_we, 1'b1);
    reset = 1'b0;
    #1;
    check("mid_rst_mem_we",    mem_we,    1'b0);
    check("mid_rst_cpu_ack",   cpu_ack,   1'b0);
    check("mid_rst_mem_addr",  mem_addr,  32'h0);
    check("mid_rst_mem_wdata", mem_wdata, 32'h0);
    check("mid_rst_cpu_rdata", cpu_rdata, 32'h0);
    check("mid_rst_dbg_rdata", dbg_rdata, 32'h0);
    check("mid_rst_cpu_stall", cpu_stall, 1'b1);
    @(posedge clock); #1;
    check("mid_rst_no_ack", cpu_ack, 1'b0);
    reset = 1'b1;
    resetModel();
    for (int i = 0; i < 3; i++) applyStimulus(1, 1, 14'h50, 32'h77, 0, 0, 0, 0);
    check("mid_rst_ram", ram[8'h50], 32'h77);

    // Random protocol-compliant traffic from both requesters.
    cp = 0; dp = 0; cw = 0; dw = 0; ca = '0; da = '0; cd = '0; dd = '0; cwait = 0; dwait = 0;
    for (int i = 0; i < 400; i++) begin
      if (!cp && $urandom_range(0, 2) != 0) begin
        cp = 1; cw = 1'($urandom_range(0, 1)); ca = 14'($urandom_range(0, 15)); cd = $urandom; cwait = 0;
      end
      if (!dp && $urandom_range(0, 2) != 0) begin
        dp = 1; dw = 1'($urandom_range(0, 1)); da = 14'($urandom_range(0, 15)); dd = $urandom; dwait = 0;
      end
      applyStimulus(cp, cw, ca, cd, dp, dw, da, dd);
      if (cp) begin
        cwait++;
        if (seen_cpu_ack) begin
          check("cpu_wait_bound", cwait <= 6, 1'b1);
          cp = 0;
        end else if (cwait > 6) begin
          check("cpu_wait_timeout", 1'b0, 1'b1);
          cp = 0;
        end
      end
      if (dp) begin
        dwait++;
        if (seen_dbg_ack) begin
          check("dbg_wait_bound", dwait <= 6, 1'b1);
          dp = 0;
        end else if (dwait > 6) begin
          check("dbg_wait_timeout", 1'b0, 1'b1);
          dp = 0;
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
